cache_flush_walker: RTL and testbench

Sequencer that walks every set and way of a set-associative cache on a flush or invalidate command. It writes back dirty lines through a request/acknowledge port and clears their dirty (and optionally valid) bits. It sits beside the cache tag/valid/dirty arrays and the replacement logic, and owns the array address while `Busy` is high. It is the cache's only source of whole-cache flush (fence-style) and invalidate sequencing.

---
 rtl/cache_flush_walker_if.sv | 29 ++
 rtl/cache_flush_walker.sv | 123 ++++++++++++
 tb/tb_cache_flush_walker.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/cache_flush_walker_if.sv
// Array-side and writeback-side signals of the cache flush walker.
// The walker uses the master modport; the cache/bus side uses slave.
interface cache_flush_walker_if #(
  parameter int NUMWAYS = 4,
  parameter int SETLEN  = 7
);
  logic               FlushReq;
  logic               Invalidate;
  logic [NUMWAYS-1:0] ValidWay;
  logic [NUMWAYS-1:0] DirtyWay;
  logic               WBAck;
  logic [SETLEN-1:0]  FlushAdr;
  logic [NUMWAYS-1:0] FlushWay;
  logic               WBReq;
  logic               ClearDirty;
  logic               ClearValid;
  logic               Busy;
  logic               FlushDone;

  modport master (
    input  FlushReq, Invalidate, ValidWay, DirtyWay, WBAck,
    output FlushAdr, FlushWay, WBReq, ClearDirty, ClearValid, Busy, FlushDone
  );

  modport slave (
    output FlushReq, Invalidate, ValidWay, DirtyWay, WBAck,
    input  FlushAdr, FlushWay, WBReq, ClearDirty, ClearValid, Busy, FlushDone
  );
endinterface

// File: rtl/cache_flush_walker.sv
// Whole-cache flush/invalidate sequencer: walks every set and way, writes back
// dirty lines and clears their dirty (and, in invalidate mode, valid) bits.
module cache_flush_walker #(
  parameter int NUMWAYS = 4,
  parameter int SETLEN  = 7
) (
  input logic                  clk,
  input logic                  resetn,
  cache_flush_walker_if.master bus
);
  typedef logic [NUMWAYS-1:0] way_t;
  typedef logic [SETLEN-1:0]  set_t;

  localparam set_t LAST_SET = '1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_CHECK,
    S_WRITEBACK,
    S_CLEAR,
    S_NEXT,
    S_DONE
  } state_t;

  state_t state, state_d, svc_state;
  set_t   counter, counter_d;
  logic   inv_q, inv_d;
  way_t   wbmask, wbmask_d;
  way_t   clrmask, clrmask_d;
  way_t   sel_way, sel_way_d;
  way_t   wb_now, clr_now, cand_wb, cand_clr, pick;

  // Isolates the lowest set bit: lowest way index has priority.
  function automatic way_t lowest(input way_t m);
    return m & (~m + way_t'(1));
  endfunction

  // Way selection shared by CHECK (fresh array read) and CLEAR (leftover masks).
  always_comb begin
    wb_now   = bus.DirtyWay & bus.ValidWay;
    clr_now  = inv_q ? bus.ValidWay : wb_now;
    cand_wb  = (state == S_CHECK) ? wb_now  : (wbmask  & ~sel_way);
    cand_clr = (state == S_CHECK) ? clr_now : (clrmask & ~sel_way);
    pick     = lowest(cand_clr);
    if (cand_clr == '0)
      svc_state = S_NEXT;
    else if ((pick & cand_wb) != '0)
      svc_state = S_WRITEBACK;
    else
      svc_state = S_CLEAR;
  end

  always_comb begin
    // NOTE: every variable gets its hold value first, so no path through the
    // case can leave one unassigned and infer a latch.
    state_d   = state;
    counter_d = counter;
    inv_d     = inv_q;
    wbmask_d  = wbmask;
    clrmask_d = clrmask;
    sel_way_d = sel_way;
    case (state)
      S_IDLE: begin
        if (bus.FlushReq) begin
          inv_d     = bus.Invalidate;
          counter_d = '0;
          state_d   = S_READ;
        end
      end
      S_READ: state_d = S_CHECK;
      S_CHECK, S_CLEAR: begin
        wbmask_d  = cand_wb;
        clrmask_d = cand_clr;
        sel_way_d = pick;
        state_d   = svc_state;
      end
      S_WRITEBACK: begin
        if (bus.WBAck) state_d = S_CLEAR;
      end
      S_NEXT: begin
        if (counter == LAST_SET) begin
          state_d = S_DONE;
        end else begin
          counter_d = counter + set_t'(1);
          state_d   = S_READ;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register updates from the
    // pre-edge values regardless of statement order.
    if (!resetn) begin
      state   <= S_IDLE;
      counter <= '0;
      inv_q   <= 1'b0;
      wbmask  <= '0;
      clrmask <= '0;
      sel_way <= '0;
    end else begin
      state   <= state_d;
      counter <= counter_d;
      inv_q   <= inv_d;
      wbmask  <= wbmask_d;
      clrmask <= clrmask_d;
      sel_way <= sel_way_d;
    end
  end

  // Outputs decode registered state only; nothing flows through from inputs.
  assign bus.FlushAdr   = counter;
  assign bus.FlushWay   = (state == S_WRITEBACK || state == S_CLEAR) ? sel_way : '0;
  assign bus.WBReq      = (state == S_WRITEBACK);
  assign bus.ClearDirty = (state == S_CLEAR);
  assign bus.ClearValid = (state == S_CLEAR) && inv_q;
  assign bus.Busy       = (state != S_IDLE);
  assign bus.FlushDone  = (state == S_DONE);

endmodule

// File: tb/tb_cache_flush_walker.sv
// Self-checking bench for cache_flush_walker: emulates the tag arrays and the
// writeback bus, and checks every walk against an event list built from the arrays.
module tb_cache_flush_walker;
  localparam int NUMWAYS  = 4;
  localparam int SETLEN   = 7;
  localparam int NUMLINES = 1 << SETLEN;
  localparam int EV_WB    = 1;
  localparam int EV_CLR   = 2;

  logic clk;
  logic resetn;

  cache_flush_walker_if #(.NUMWAYS(NUMWAYS), .SETLEN(SETLEN)) bus ();

  cache_flush_walker #(.NUMWAYS(NUMWAYS), .SETLEN(SETLEN)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  logic [NUMWAYS-1:0] valid_arr [NUMLINES];
  logic [NUMWAYS-1:0] dirty_arr [NUMLINES];

  int compared   = 0;
  int mismatched = 0;
  int exp_q[$];
  int got_q[$];
  int delays[$];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Synchronous-read arrays: address seen in one cycle, data valid the next.
  initial begin : array_port
    logic [SETLEN-1:0] rd_adr;
    bus.ValidWay = '0;
    bus.DirtyWay = '0;
    forever begin
      @(negedge clk);
      rd_adr = bus.FlushAdr;
      @(posedge clk);
      #1;
      bus.ValidWay = valid_arr[rd_adr];
      bus.DirtyWay = dirty_arr[rd_adr];
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int ev(input int kind, input int s, input logic [NUMWAYS-1:0] way, input bit cv);
    return (kind << 24) | (s << 8) | (int'(way) << 1) | int'(cv);
  endfunction

  function automatic logic [31:0] outvec();
    return 32'({bus.FlushAdr, bus.FlushWay, bus.WBReq, bus.ClearDirty,
                bus.ClearValid, bus.Busy, bus.FlushDone});
  endfunction

  task automatic clear_arrays();
    for (int s = 0; s < NUMLINES; s++) begin
      valid_arr[s] = '0;
      dirty_arr[s] = '0;
    end
  endtask

  // One full walk: expected events and completion cycle come from the array
  // contents and the chosen acknowledge delays, then the DUT is observed.
  task automatic run_walk(input string name, input bit inv, input int min_d,
                          input int max_d, input bit poke);
    int exp_done, cycle, done_cycle, k, wb_cnt, cur_d, poke_at;
    int bad_busy, bad_way, bad_wb, bad_adr, n, idle_bad;
    logic [SETLEN-1:0]  prev_adr, wb_adr;
    logic [NUMWAYS-1:0] wb_way, oh, residual;
    bit in_wb;

    exp_q.delete();
    got_q.delete();
    delays.delete();
    exp_done = 1;
    for (int s = 0; s < NUMLINES; s++) begin
      exp_done += 3;
      for (int w = 0; w < NUMWAYS; w++) begin
        oh = '0;
        oh[w] = 1'b1;
        if (valid_arr[s][w] && (inv || dirty_arr[s][w])) begin
          if (dirty_arr[s][w]) begin
            cur_d = $urandom_range(max_d, min_d);
            delays.push_back(cur_d);
            exp_q.push_back(ev(EV_WB, s, oh, 1'b0));
            exp_done += cur_d + 1;
          end
          exp_q.push_back(ev(EV_CLR, s, oh, inv));
          exp_done += 1;
        end
      end
    end

    poke_at = poke ? $urandom_range(exp_done - 1, 2) : -1;
    bus.FlushReq   = 1'b1;
    bus.Invalidate = inv;
    bus.WBAck      = 1'b0;
    @(negedge clk);
    bus.FlushReq   = 1'b0;
    bus.Invalidate = 1'($urandom);

    cycle = 1; done_cycle = -1; k = 0; in_wb = 0; wb_cnt = 0; cur_d = 0;
    bad_busy = 0; bad_way = 0; bad_wb = 0; bad_adr = 0;
    wb_adr = '0; wb_way = '0;
    check({name, " first adr"}, 32'(bus.FlushAdr), 0);
    prev_adr = bus.FlushAdr;

    while (cycle <= exp_done + 64) begin
      if (bus.Busy !== 1'b1) bad_busy++;
      if (bus.FlushAdr !== prev_adr && int'(bus.FlushAdr) != int'(prev_adr) + 1) bad_adr++;
      prev_adr = bus.FlushAdr;

      if (bus.WBReq === 1'b1) begin
        if (!in_wb) begin
          in_wb  = 1;
          wb_cnt = 0;
          wb_adr = bus.FlushAdr;
          wb_way = bus.FlushWay;
          got_q.push_back(ev(EV_WB, int'(bus.FlushAdr), bus.FlushWay, 1'b0));
          cur_d = (k < delays.size()) ? delays[k] : 0;
          k++;
        end else if (bus.FlushAdr !== wb_adr || bus.FlushWay !== wb_way) begin
          bad_wb++;
        end
        bus.WBAck = (wb_cnt == cur_d);
        wb_cnt++;
      end else begin
        in_wb = 0;
        bus.WBAck = 1'($urandom);
      end

      if (bus.ClearDirty === 1'b1) begin
        got_q.push_back(ev(EV_CLR, int'(bus.FlushAdr), bus.FlushWay, bus.ClearValid));
        dirty_arr[bus.FlushAdr] &= ~bus.FlushWay;
        if (bus.ClearValid) valid_arr[bus.FlushAdr] &= ~bus.FlushWay;
      end else if (bus.ClearValid !== 1'b0) begin
        bad_way++;
      end

      if (bus.WBReq || bus.ClearDirty) begin
        if (!$onehot(bus.FlushWay)) bad_way++;
      end else if (bus.FlushWay !== '0) begin
        bad_way++;
      end

      if (bus.FlushDone === 1'b1) begin
        done_cycle = cycle;
        break;
      end
      bus.FlushReq = (cycle == poke_at);
      @(negedge clk);
      cycle++;
    end
    bus.FlushReq = 1'b0;
    bus.WBAck    = 1'b0;

    check({name, " done cycle"}, done_cycle, exp_done);
    check({name, " busy held"}, bad_busy, 0);
    check({name, " way decode"}, bad_way, 0);
    check({name, " wb stable"}, bad_wb, 0);
    check({name, " adr steps"}, bad_adr, 0);
    check({name, " last adr"}, 32'(prev_adr), NUMLINES - 1);
    check({name, " event count"}, got_q.size(), exp_q.size());
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++)
      check($sformatf("%s ev%0d", name, i), got_q[i], exp_q[i]);

    idle_bad = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (bus.Busy !== 1'b0 || bus.FlushDone !== 1'b0) idle_bad++;
    end
    check({name, " idle after done"}, idle_bad, 0);

    residual = '0;
    for (int s = 0; s < NUMLINES; s++)
      residual |= valid_arr[s] & (inv ? {NUMWAYS{1'b1}} : dirty_arr[s]);
    check({name, " arrays cleaned"}, 32'(residual), 0);
  endtask

  initial begin
    bit found;
    resetn         = 1'b0;
    bus.FlushReq   = 1'b0;
    bus.Invalidate = 1'b0;
    bus.WBAck      = 1'b0;
    clear_arrays();
    repeat (3) @(negedge clk);
    check("reset outputs", outvec(), 0);
    resetn = 1'b1;
    @(negedge clk);
    check("idle outputs", outvec(), 0);

    run_walk("clean", 1'b0, 0, 0, 1'b0);

    valid_arr[5] = 4'b1111;
    dirty_arr[5] = 4'b1010;
    run_walk("set5 flush", 1'b0, 0, 0, 1'b0);

    dirty_arr[5] = 4'b1010;
    run_walk("set5 invalidate", 1'b1, 0, 0, 1'b0);

    valid_arr[7] = 4'b0100;
    dirty_arr[7] = 4'b0100;
    run_walk("ack delay", 1'b0, 3, 3, 1'b0);

    // Reset in the middle of a writeback on set 10.
    valid_arr[10] = 4'b0011;
    dirty_arr[10] = 4'b0010;
    bus.FlushReq  = 1'b1;
    @(negedge clk);
    bus.FlushReq = 1'b0;
    found = 0;
    for (int c = 0; c < 2000 && !found; c++) begin
      if (bus.WBReq === 1'b1 && bus.FlushAdr == 10) found = 1;
      else @(negedge clk);
    end
    check("rst reached set10 wb", 32'(found), 1);
    resetn = 1'b0;
    @(negedge clk);
    check("rst mid writeback", outvec(), 0);
    resetn = 1'b1;
    @(negedge clk);
    check("rst stays idle", outvec(), 0);
    run_walk("after reset", 1'b0, 0, 1, 1'b0);

    valid_arr[20] = 4'b0000;
    dirty_arr[20] = 4'b0100;
    valid_arr[30] = 4'b1001;
    dirty_arr[30] = 4'b1000;
    run_walk("poke busy", 1'b0, 0, 2, 1'b1);

    for (int r = 0; r < 6; r++) begin
      for (int s = 0; s < NUMLINES; s++) begin
        valid_arr[s] = NUMWAYS'($urandom);
        dirty_arr[s] = NUMWAYS'($urandom) & NUMWAYS'($urandom);
      end
      run_walk($sformatf("rand%0d", r), 1'($urandom), 0, 2, 1'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
